control_unit: RTL

Instruction-sequencing FSM for the 8-bit CPU; it is the controller side of the `data_path` control interface. It fetches opcodes through `data_path`, decodes `IR`, and drives every load, select and ALU control line, plus the memory `write` strobe. Each instruction runs as a fixed, cycle-exact state sequence: fetch, decode, then execute.

---
 rtl/control_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Instruction-sequencing Moore FSM for the 8-bit CPU: fetch, decode, execute.
// Define CU_COND_BRANCH_EN to decode the conditional branches (opcodes 21-28).
module control_unit (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] IR,
  input  logic [3:0] CCR_Result,
  output logic       IR_Load,
  output logic       MAR_Load,
  output logic       PC_Load,
  output logic       PC_Inc,
  output logic       A_Load,
  output logic       B_Load,
  output logic       CCR_Load,
  output logic [2:0] ALU_Sel,
  output logic [1:0] Bus1_Sel,
  output logic [1:0] Bus2_Sel,
  output logic       write
);

  // state | meaning
  // F0    | PC -> MAR
  // F1    | PC increment
  // F2    | memory -> IR
  // DEC   | decode IR (and CCR for conditional branches)
  // E0-E4 | execute steps; the path is held in op/use_b, latched in DEC
  typedef enum logic [3:0] {
    S_F0, S_F1, S_F2, S_DEC, S_E0, S_E1, S_E2, S_E3, S_E4
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP, OP_LD_IMM, OP_LD_DIR, OP_ST_DIR, OP_ALU, OP_BRA, OP_BR_SKIP
  } op_t;

  state_t state, state_nxt;
  op_t    op, op_nxt, dec_op;
  logic   use_b, use_b_nxt, dec_b;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_F0;
      op    <= OP_NOP;
      use_b <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      use_b <= use_b_nxt;
    end
  end

`ifdef CU_COND_BRANCH_EN
  // Opcodes 21..28 pair up on one flag each (N,Z,V,C); odd opcodes branch on flag=1.
  logic [3:0] br_idx;
  logic       br_taken;
  always_comb begin
    br_idx   = IR[3:0] - 4'd1;
    br_taken = (CCR_Result[3 - br_idx[2:1]] == IR[0]);
  end
`else
  logic unused_ccr;
  assign unused_ccr = ^CCR_Result;
`endif

  always_comb begin
    dec_op = OP_NOP;
    dec_b  = 1'b0;
    case (IR)
      8'h86: dec_op = OP_LD_IMM;
      8'h88: begin dec_op = OP_LD_IMM; dec_b = 1'b1; end
      8'h87: dec_op = OP_LD_DIR;
      8'h89: begin dec_op = OP_LD_DIR; dec_b = 1'b1; end
      8'h96: dec_op = OP_ST_DIR;
      8'h97: begin dec_op = OP_ST_DIR; dec_b = 1'b1; end
      8'h42: dec_op = OP_ALU;
      8'h43: begin dec_op = OP_ALU; dec_b = 1'b1; end
      8'h20: dec_op = OP_BRA;
`ifdef CU_COND_BRANCH_EN
      8'h21, 8'h22, 8'h23, 8'h24,
      8'h25, 8'h26, 8'h27, 8'h28: dec_op = br_taken ? OP_BRA : OP_BR_SKIP;
`endif
      default: dec_op = OP_NOP;
    endcase
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    use_b_nxt = use_b;
    case (state)
      S_F0: state_nxt = S_F1;
      S_F1: state_nxt = S_F2;
      S_F2: state_nxt = S_DEC;
      S_DEC: begin
        op_nxt    = dec_op;
        use_b_nxt = dec_b;
        state_nxt = (dec_op == OP_NOP) ? S_F0 : S_E0;
      end
      S_E0: state_nxt = (op == OP_ALU || op == OP_BR_SKIP) ? S_F0 : S_E1;
      S_E1: state_nxt = S_E2;
      S_E2: state_nxt = (op == OP_LD_IMM || op == OP_BRA) ? S_F0 : S_E3;
      S_E3: state_nxt = (op == OP_ST_DIR) ? S_F0 : S_E4;
      S_E4: state_nxt = S_F0;
      default: state_nxt = S_F0;
    endcase
  end

  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    ALU_Sel  = 3'b000;
    Bus1_Sel = 2'b00;
    Bus2_Sel = 2'b00;
    write    = 1'b0;
    // Reset gates every output so an aborted write or load never reaches data_path.
    if (!Reset) begin
      case (state)
        S_F0: begin Bus2_Sel = 2'b01; MAR_Load = 1'b1; end
        S_F1: PC_Inc = 1'b1;
        S_F2: begin Bus2_Sel = 2'b10; IR_Load = 1'b1; end
        S_E0: begin
          case (op)
            OP_ALU: begin
              Bus1_Sel = 2'b01;
              ALU_Sel  = use_b ? 3'b010 : 3'b000;
              A_Load   = 1'b1;
              CCR_Load = 1'b1;
            end
            OP_BR_SKIP: PC_Inc = 1'b1;
            OP_LD_IMM, OP_LD_DIR, OP_ST_DIR, OP_BRA: begin
              Bus2_Sel = 2'b01;
              MAR_Load = 1'b1;
            end
            default: ;
          endcase
        end
        S_E1: PC_Inc = (op != OP_BRA);
        S_E2: begin
          Bus2_Sel = 2'b10;
          case (op)
            OP_LD_IMM: begin A_Load = !use_b; B_Load = use_b; end
            OP_LD_DIR, OP_ST_DIR: MAR_Load = 1'b1;
            OP_BRA: PC_Load = 1'b1;
            default: ;
          endcase
        end
        S_E3: begin
          if (op == OP_ST_DIR) begin
            Bus1_Sel = use_b ? 2'b10 : 2'b01;
            write    = 1'b1;
          end
        end
        S_E4: begin
          Bus2_Sel = 2'b10;
          A_Load   = !use_b;
          B_Load   = use_b;
        end
        default: ;
      endcase
    end
  end

endmodule
